multdiv_sequencer: RTL

Multi-cycle HI/LO multiply unit and its controller for the single-cycle MIPS core. The decoder flags multu, mfhi and mflo, and this block does the rest:
- accepts a multu start;
- runs a shift-add multiply over several cycles;
- owns the HI/LO architectural registers;
- stalls the pipeline when an mfhi/mflo or a new multu arrives while a multiply is in flight.

---
 rtl/multdiv_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// HI/LO shift-add multiplier: multu accepted in IDLE/DONE, WIDTH/STEP_BITS RUN cycles, one-cycle done; stall = busy & (rd_req | start).
// Optional MULT_SIGNED_EN adds is_signed (mult): magnitudes are multiplied and the product is negated on the DONE edge.
module multdiv_sequencer #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             rd_req,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH-1:0]   opa_l;
  logic [WIDTH-1:0]   opa_in;
  logic [WIDTH-1:0]   opb_in;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] product;

`ifdef MULT_SIGNED_EN
  logic neg;
  logic neg_in;

  always_comb begin
    opa_in = (is_signed && opa[WIDTH-1]) ? -opa : opa;
    opb_in = (is_signed && opb[WIDTH-1]) ? -opb : opb;
    neg_in = is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
  end

  assign product = neg ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
`else
  assign opa_in  = opa;
  assign opb_in  = opb;
  assign product = acc_step[2*WIDTH-1:0];
`endif

  // Upper add is WIDTH+1 wide; the shift pulls that carry back into the product.
  always_comb begin
    acc_step = acc;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (acc_step[0])
        acc_step[2*WIDTH:WIDTH] = acc_step[2*WIDTH:WIDTH] + {1'b0, opa_l};
      acc_step = acc_step >> 1;
    end
  end

  assign stall = busy & (rd_req | start);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      opa_l <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULT_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opa_l <= opa_in;
            acc   <= {{(WIDTH+1){1'b0}}, opb_in};
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MULT_SIGNED_EN
            neg   <= neg_in;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (count == CW'(N-1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= product[2*WIDTH-1:WIDTH];
            lo    <= product[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
